// File: rtl/sens_or_stim_checker.sv
// rtl/sens_or_stim_checker.sv - LFSR stimulus generator and checker for a combinational a & b consumer
module sens_or_stim_checker #(
    parameter int         NUM_VECTORS   = 16,
    parameter logic [7:0] SEED          = 8'hA5,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] result,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] vec_idx
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_IDX    = 8'(NUM_VECTORS - 1);
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] settle_q, settle_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] err_q, err_d;
    logic [7:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    // Operand B is the nibble-swapped, inverted LFSR value.
    function automatic logic [7:0] op_b(input logic [7:0] l);
        return ~{l[3:0], l[7:4]};
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Next-state logic: vector 0 loads both operands, then odd vectors touch only b
    // and even vectors touch only a, so each sensitivity-list entry is exercised alone.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        exp_d    = exp_q;
        settle_d = settle_q;
        lfsr_d   = lfsr_q;
        err_d    = err_q;
        vec_d    = vec_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (vec_q == 8'd0) begin
                    a_d = lfsr_q;
                    b_d = op_b(lfsr_q);
                end else if (vec_q[0]) begin
                    b_d = op_b(lfsr_q);
                end else begin
                    a_d = lfsr_q;
                end
                exp_d    = a_d & b_d;
                settle_d = SETTLE_INIT;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q <= 8'd1) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            S_CHECK: begin
                if ((result != exp_q) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
                if (vec_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 8'd1;
                    lfsr_d  = lfsr_next(lfsr_q);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                if (start) begin
                    err_d   = 8'd0;
                    vec_d   = 8'd0;
                    lfsr_d  = SEED_EFF;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == 8'd0);
    end

    // State and registered outputs; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            exp_q    <= 8'd0;
            settle_q <= 8'd0;
            lfsr_q   <= SEED_EFF;
            err_q    <= 8'd0;
            vec_q    <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            exp_q    <= exp_d;
            settle_q <= settle_d;
            lfsr_q   <= lfsr_d;
            err_q    <= err_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_idx   = vec_q;

endmodule

// File: doc/sens_or_stim_checker.md
Name: sens_or_stim_checker

Overview:
- Self-checking stimulus generator and response checker for a combinational consumer that computes result = a & b through an explicit `always @(a or b)` sensitivity list.
- Produces an LFSR-derived operand stream in which a and b change in separate cycles, so each signal in the sensitivity list is exercised on its own.
- Samples the consumer's result after a settle window, compares it with an internally registered expected value, and counts mismatches.
- Its own sequential logic uses the `always @(posedge clk or negedge rst_n)` form, giving the simulator both event-list flavours in one test.

Parameters:
- NUM_VECTORS, 16, number of operand vectors per run; must be 1..255.
- SEED, 8'hA5, LFSR seed; 8'h00 is replaced by 8'h01 at load.
- SETTLE_CYCLES, 2, cycles between an operand update and result sampling; must be at least 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- result  input  8  consumer output, expected to equal a & b.
- a  output  8  operand A, registered.
- b  output  8  operand B, registered.
- busy  output  1  high in LOAD, SETTLE and CHECK.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when err_count==0; 0 elsewhere.
- err_count  output  8  mismatch count, saturates at 8'hFF.
- vec_idx  output  8  index of the vector currently being checked.

Behaviour:
- Reset (async assert, sync release) values:
  - a=0, b=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0.
  - lfsr=SEED (0 mapped to 8'h01), state=IDLE.
  - An assertion mid-run aborts immediately.
- LFSR:
  - 8-bit Fibonacci, fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0], fb}.
  - Advances once per vector after the first.
  - opB(l) = ~{l[3:0], l[7:4]}.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD (1 cycle):
    - vec_idx==0: a<=lfsr and b<=opB(lfsr).
    - Odd vec_idx: b<=opB(lfsr) only; a holds.
    - Even vec_idx>0: a<=lfsr only; b holds.
    - expected<=new a & new b.
    - Settle counter <= SETTLE_CYCLES.
    - -> SETTLE.
  - SETTLE: decrement each cycle; at 1 -> CHECK. a and b are stable throughout.
  - CHECK (1 cycle):
    - result!=expected: err_count += 1, saturating.
    - vec_idx==NUM_VECTORS-1 -> DONE.
    - Otherwise vec_idx+=1, lfsr advances, -> LOAD.
  - DONE:
    - done=1, pass=(err_count==0).
    - a, b, err_count and vec_idx hold.
    - start=1: err_count<=0, vec_idx<=0, lfsr<=SEED (0 mapped to 8'h01), -> LOAD. done and pass drop that cycle.
- Latency:
  - start to first LOAD: 1 cycle.
  - Per vector: 1 + SETTLE_CYCLES + 1 cycles.
- start while busy is ignored; no restart and no counter change.
- result is sampled only in CHECK, so glitches during SETTLE are ignored.
- err_count at 8'hFF stays at 8'hFF.

Test Plan:
1. Reset, SEED=A5, NUM_VECTORS=2, result wired to a golden `always @(a or b)` AND:
   - Vector 0: a=A5, b=A5, expected=A5.
   - Vector 1: lfsr=4A, b=5B, a stays A5, expected=01.
   - Then done=1, pass=1, err_count=0, vec_idx=1.
2. result tied to 8'h00, NUM_VECTORS=2 -> both vectors mismatch; err_count=2, pass=0, done=1.
3. Consumer with b removed from its sensitivity list (stale output on b-only updates), NUM_VECTORS=16 -> err_count is nonzero, counts only odd-vector failures, and pass=0.
4. Pulse start during SETTLE of vector 3 -> no restart; vec_idx continues to 15; total run is 16×(2+SETTLE_CYCLES)+1 cycles from the first start.
5. Drop rst_n during CHECK of vector 5 -> outputs go to reset values within the same cycle, with no clk edge needed; after release, start reruns from vector 0 with a=A5.
6. SEED=0, NUM_VECTORS=1 -> lfsr loads 01: a=01, b=~8'h10=EF, expected=01; done=1, pass=1 with the golden consumer.
